// File: rtl/adc_modulation.sv
// Charge-balance run-up controller answering the acquisition sequencer.
// Optional rundown phase is built when ADC_RUNDOWN_EN is defined.
module adc_modulation #(
  parameter int SYNC_STAGES = 2
`ifdef ADC_RUNDOWN_EN
  , parameter int RUNDOWN_TIMEOUT = 4095
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_reset_n_i,
  input  logic [23:0] p_clk_count_aper_i,
  input  logic [7:0]  p_clk_count_fix_i,
  input  logic        cmpr_val_i,
  output logic        sigmux_o,
  output logic [1:0]  refmux_o,
  output logic        adc_measure_valid_o,
  output logic [23:0] count_up_o,
  output logic [23:0] count_down_o,
  output logic [23:0] clk_count_runup_o,
  output logic [23:0] clk_count_rundown_o
);

  // state   | meaning
  // IDLE    | muxes off, last result still readable
  // START   | latch parameters, clear counts, connect signal
  // RUNUP   | modulation cycles, reference chosen per cycle
  // RUNDOWN | single reference until comparator crossing or timeout
  // DONE    | results valid and held
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUNUP   = 3'd2,
`ifdef ADC_RUNDOWN_EN
    S_RUNDOWN = 3'd3,
`endif
    S_DONE    = 3'd4
  } state_t;

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  state_t             state_q, state_d;
  logic [SYNC_N-1:0]  sync_q;
  logic               cmpr_s;
  logic [23:0]        aper_q, aper_d;
  logic [7:0]         fix_q, fix_d;
  logic [7:0]         cyc_q, cyc_d;
  logic               sigmux_q, sigmux_d;
  logic [1:0]         refmux_q, refmux_d;
  logic               valid_q, valid_d;
  logic [23:0]        up_q, up_d;
  logic [23:0]        down_q, down_d;
  logic [23:0]        runup_q, runup_d;
`ifdef ADC_RUNDOWN_EN
  localparam logic [23:0] RD_LIMIT = 24'(RUNDOWN_TIMEOUT);
  logic               samp_q, samp_d;
  logic [23:0]        rundown_q, rundown_d;
`endif

  assign cmpr_s = sync_q[SYNC_N-1];

  always_comb begin
    state_d  = state_q;
    aper_d   = aper_q;
    fix_d    = fix_q;
    cyc_d    = cyc_q;
    sigmux_d = sigmux_q;
    refmux_d = refmux_q;
    valid_d  = valid_q;
    up_d     = up_q;
    down_d   = down_q;
    runup_d  = runup_q;
`ifdef ADC_RUNDOWN_EN
    samp_d    = samp_q;
    rundown_d = rundown_q;
`endif
    if (!adc_reset_n_i) begin
      state_d  = S_IDLE;
      sigmux_d = 1'b0;
      refmux_d = 2'b00;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sigmux_d = 1'b0;
          refmux_d = 2'b00;
          valid_d  = 1'b0;
          state_d  = S_START;
        end
        S_START: begin
          aper_d   = p_clk_count_aper_i;
          fix_d    = (p_clk_count_fix_i < 8'd2) ? 8'd2 : p_clk_count_fix_i;
          cyc_d    = 8'd0;
          up_d     = 24'd0;
          down_d   = 24'd0;
          runup_d  = 24'd0;
`ifdef ADC_RUNDOWN_EN
          rundown_d = 24'd0;
`endif
          sigmux_d = 1'b1;
          refmux_d = 2'b00;
          state_d  = S_RUNUP;
        end
        S_RUNUP: begin
          runup_d = runup_q + 24'd1;
          if (cyc_q == 8'd0) begin
            refmux_d = cmpr_s ? 2'b10 : 2'b01;
            if (cmpr_s) down_d = down_q + 24'd1;
            else        up_d   = up_q + 24'd1;
          end
          // fix >= 2, so a cycle's first and last clocks never coincide
          if (cyc_q == fix_q - 8'd1) begin
            cyc_d = 8'd0;
            if (runup_q + 24'd1 >= aper_q) begin
              sigmux_d = 1'b0;
`ifdef ADC_RUNDOWN_EN
              refmux_d = cmpr_s ? 2'b10 : 2'b01;
              samp_d   = cmpr_s;
              state_d  = S_RUNDOWN;
`else
              refmux_d = 2'b00;
              state_d  = S_DONE;
`endif
            end
          end else begin
            cyc_d = cyc_q + 8'd1;
          end
        end
`ifdef ADC_RUNDOWN_EN
        S_RUNDOWN: begin
          if (cmpr_s != samp_q) begin
            refmux_d = 2'b00;
            state_d  = S_DONE;
          end else begin
            rundown_d = rundown_q + 24'd1;
            if (rundown_q + 24'd1 >= RD_LIMIT) begin
              refmux_d = 2'b00;
              state_d  = S_DONE;
            end
          end
        end
`endif
        S_DONE: valid_d = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      aper_q   <= 24'd0;
      fix_q    <= 8'd2;
      cyc_q    <= 8'd0;
      sigmux_q <= 1'b0;
      refmux_q <= 2'b00;
      valid_q  <= 1'b0;
      up_q     <= 24'd0;
      down_q   <= 24'd0;
      runup_q  <= 24'd0;
`ifdef ADC_RUNDOWN_EN
      samp_q    <= 1'b0;
      rundown_q <= 24'd0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_N-2:0], cmpr_val_i};
      aper_q   <= aper_d;
      fix_q    <= fix_d;
      cyc_q    <= cyc_d;
      sigmux_q <= sigmux_d;
      refmux_q <= refmux_d;
      valid_q  <= valid_d;
      up_q     <= up_d;
      down_q   <= down_d;
      runup_q  <= runup_d;
`ifdef ADC_RUNDOWN_EN
      samp_q    <= samp_d;
      rundown_q <= rundown_d;
`endif
    end
  end

  assign sigmux_o            = sigmux_q;
  assign refmux_o            = refmux_q;
  assign adc_measure_valid_o = valid_q;
  assign count_up_o          = up_q;
  assign count_down_o        = down_q;
  assign clk_count_runup_o   = runup_q;
`ifdef ADC_RUNDOWN_EN
  assign clk_count_rundown_o = rundown_q;
`else
  assign clk_count_rundown_o = 24'd0;
`endif

endmodule

// File: tb/tb_adc_modulation.sv
// Directed bench for adc_modulation: run-up counts, timing, abort and sequencer loop.
module tb_adc_modulation;

  logic        clk = 1'b0;
  logic        reset;
  logic        adc_reset_n;
  logic [23:0] aper;
  logic [7:0]  fix;
  logic        cmpr;
  logic        sigmux;
  logic [1:0]  refmux;
  logic        valid;
  logic [23:0] cnt_up, cnt_down, cnt_runup, cnt_rundown;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  adc_modulation #(
    .SYNC_STAGES(2)
`ifdef ADC_RUNDOWN_EN
    , .RUNDOWN_TIMEOUT(40)
`endif
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .adc_reset_n_i       (adc_reset_n),
    .p_clk_count_aper_i  (aper),
    .p_clk_count_fix_i   (fix),
    .cmpr_val_i          (cmpr),
    .sigmux_o            (sigmux),
    .refmux_o            (refmux),
    .adc_measure_valid_o (valid),
    .count_up_o          (cnt_up),
    .count_down_o        (cnt_down),
    .clk_count_runup_o   (cnt_runup),
    .clk_count_rundown_o (cnt_rundown)
  );

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int cnt);
    cnt = 0;
    while (valid !== 1'b1 && cnt < max) begin
      step(1);
      cnt++;
    end
    chk("valid_seen", {23'd0, valid}, 24'd1);
  endtask

  initial begin
    reset = 1'b1; adc_reset_n = 1'b0; aper = 24'd0; fix = 8'd0; cmpr = 1'b0;
    step(3);
    chk("rst_sigmux", {23'd0, sigmux}, 24'd0);
    chk("rst_refmux", {22'd0, refmux}, 24'd0);
    chk("rst_valid", {23'd0, valid}, 24'd0);
    chk("rst_up", cnt_up, 24'd0);
    chk("rst_runup", cnt_runup, 24'd0);
    reset = 1'b0;
    step(1);
    chk("idle_sigmux", {23'd0, sigmux}, 24'd0);

    // T1: fix=4 aper=20 cmpr=0
    aper = 24'd20; fix = 8'd4; cmpr = 1'b0; adc_reset_n = 1'b1;
`ifndef ADC_RUNDOWN_EN
    step(2);
    chk("t1_start_sigmux", {23'd0, sigmux}, 24'd1);
    chk("t1_start_refmux", {22'd0, refmux}, 24'd0);
    step(1);
    chk("t1_first_refmux", {22'd0, refmux}, 24'd1);
    step(18);
    chk("t1_late_refmux", {22'd0, refmux}, 24'd1);
    chk("t1_late_sigmux", {23'd0, sigmux}, 24'd1);
    chk("t1_late_runup", cnt_runup, 24'd19);
    step(1);
    chk("t1_end_sigmux", {23'd0, sigmux}, 24'd0);
    chk("t1_end_refmux", {22'd0, refmux}, 24'd0);
    chk("t1_end_valid", {23'd0, valid}, 24'd0);
    step(1);
    chk("t1_valid", {23'd0, valid}, 24'd1);
    chk("t1_rundown", cnt_rundown, 24'd0);
`else
    wait_valid(200, n);
`endif
    chk("t1_up", cnt_up, 24'd5);
    chk("t1_down", cnt_down, 24'd0);
    chk("t1_runup", cnt_runup, 24'd20);
    adc_reset_n = 1'b0;
    step(1);
    chk("t1_drop_valid", {23'd0, valid}, 24'd0);
    chk("t1_held_up", cnt_up, 24'd5);

    // T2: fix=4 aper=18, comparator alternates per cycle starting high
    aper = 24'd18; fix = 8'd4; cmpr = 1'b1; adc_reset_n = 1'b1;
    step(4); cmpr = 1'b0;
    step(4); cmpr = 1'b1;
    step(4); cmpr = 1'b0;
    step(4); cmpr = 1'b1;
    wait_valid(200, n);
`ifndef ADC_RUNDOWN_EN
    chk("t2_latency", 24'(n), 24'd7);
`endif
    chk("t2_down", cnt_down, 24'd3);
    chk("t2_up", cnt_up, 24'd2);
    chk("t2_runup", cnt_runup, 24'd20);
    adc_reset_n = 1'b0;
    step(1);

    // T3: fix=1 is treated as 2, aper=0 gives one cycle
    aper = 24'd0; fix = 8'd1; cmpr = 1'b0; adc_reset_n = 1'b1;
    wait_valid(200, n);
`ifndef ADC_RUNDOWN_EN
    chk("t3_latency", 24'(n), 24'd5);
`endif
    chk("t3_up", cnt_up, 24'd1);
    chk("t3_down", cnt_down, 24'd0);
    chk("t3_runup", cnt_runup, 24'd2);
    adc_reset_n = 1'b0;
    step(1);

    // T4: abort after 7 run-up clocks, then restart
    aper = 24'd40; fix = 8'd4; cmpr = 1'b0; adc_reset_n = 1'b1;
    step(9);
    chk("t4_pre_sigmux", {23'd0, sigmux}, 24'd1);
    chk("t4_pre_refmux", {22'd0, refmux}, 24'd1);
    adc_reset_n = 1'b0;
    step(1);
    chk("t4_abort_sigmux", {23'd0, sigmux}, 24'd0);
    chk("t4_abort_refmux", {22'd0, refmux}, 24'd0);
    chk("t4_abort_valid", {23'd0, valid}, 24'd0);
    chk("t4_abort_runup", cnt_runup, 24'd7);
    chk("t4_abort_cycles", cnt_up + cnt_down, 24'd2);
    step(1);
    chk("t4_frozen_runup", cnt_runup, 24'd7);
    adc_reset_n = 1'b1;
    step(2);
    chk("t4_restart_runup", cnt_runup, 24'd0);
    chk("t4_restart_up", cnt_up, 24'd0);
    wait_valid(300, n);
`ifndef ADC_RUNDOWN_EN
    chk("t4_latency", 24'(n), 24'd41);
`endif
    chk("t4_up", cnt_up, 24'd10);
    chk("t4_runup", cnt_runup, 24'd40);
    adc_reset_n = 1'b0;
    step(1);

    // reset overrides an active measurement
    adc_reset_n = 1'b1;
    step(6);
    reset = 1'b1;
    step(1);
    chk("rst_ovr_sigmux", {23'd0, sigmux}, 24'd0);
    chk("rst_ovr_runup", cnt_runup, 24'd0);
    chk("rst_ovr_up", cnt_up, 24'd0);
    reset = 1'b0; adc_reset_n = 1'b0;
    step(1);

    // T5: sequencer loop, three back-to-back measurements
    for (int i = 0; i < 3; i++) begin
      aper = 24'd10; fix = 8'd3; cmpr = 1'b0; adc_reset_n = 1'b1;
      wait_valid(200, n);
`ifndef ADC_RUNDOWN_EN
      chk("t5_latency", 24'(n), 24'd15);
`endif
      chk("t5_up", cnt_up, 24'd4);
      chk("t5_down", cnt_down, 24'd0);
      chk("t5_runup", cnt_runup, 24'd12);
      adc_reset_n = 1'b0;
      step(1);
      chk("t5_valid_low", {23'd0, valid}, 24'd0);
      step(1);
      chk("t5_valid_stays_low", {23'd0, valid}, 24'd0);
    end

`ifdef ADC_RUNDOWN_EN
    // T6a: rundown with comparator crossing
    aper = 24'd8; fix = 8'd4; cmpr = 1'b1; adc_reset_n = 1'b1;
    step(11);
    chk("t6_rd_refmux", {22'd0, refmux}, 24'd2);
    chk("t6_rd_sigmux", {23'd0, sigmux}, 24'd0);
    step(8);
    cmpr = 1'b0;
    wait_valid(200, n);
    chk("t6_rundown", cnt_rundown, 24'd11);
    chk("t6_refmux_off", {22'd0, refmux}, 24'd0);
    chk("t6_down", cnt_down, 24'd2);
    adc_reset_n = 1'b0;
    step(1);
    // T6b: no crossing, rundown stops at the timeout
    cmpr = 1'b1; adc_reset_n = 1'b1;
    wait_valid(300, n);
    chk("t6_timeout", cnt_rundown, 24'd40);
    adc_reset_n = 1'b0;
    step(1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
